// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer: frame and
// decode state encodings, the queued event record and the prefix bytes.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_DATA,
        FRM_PARITY,
        FRM_STOP
    } frame_state_e;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } decode_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Odd parity: the data ones plus the parity bit must be an odd count.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguishable; a push into a full FIFO is accepted
// only when the head is popped in the same cycle, otherwise it is dropped.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  ps2_evt_t push_data_i,
    input  logic     pop_i,
    output logic     valid_o,
    output ps2_evt_t head_o,
    output logic     overflow_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ps2_evt_t      mem [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          empty;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = 1'b0;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_i && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // When full with a simultaneous pop, the write lands in the slot being
    // vacated by the head, which then becomes the tail.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign valid_o    = !empty;
    assign head_o     = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, assembles 11-bit
// frames, folds E0/F0 prefixes into {ext,brk,code} events and queues them.
// Define PS2_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle cycles.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       frame_err,
    output logic       overflow
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two between 2 and 16");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    logic          ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
    logic          ps2_data_meta_q, ps2_data_sync_q;
    logic          fall;
    logic          sample_bit;

    frame_state_e  frm_q, frm_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout_hit;

    decode_state_e dec_q, dec_d;
    logic          push;
    ps2_evt_t      push_evt;
    ps2_evt_t      head_evt;
    logic          fifo_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_prev_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_prev_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign fall       = ps2_clk_prev_q && !ps2_clk_sync_q;
    assign sample_bit = ps2_data_sync_q;

`ifdef PS2_TIMEOUT_EN
    localparam int             TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (frm_q == FRM_IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LIMIT) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // A genuine edge in the same cycle takes precedence over the abort.
    assign timeout_hit = (frm_q != FRM_IDLE) && !fall && (to_cnt_q == TO_LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        frm_d        = frm_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (timeout_hit) begin
            frm_d       = FRM_IDLE;
            frame_err_d = 1'b1;
        end else if (fall) begin
            unique case (frm_q)
                FRM_IDLE: begin
                    if (!sample_bit) begin
                        frm_d     = FRM_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                FRM_DATA: begin
                    shift_d   = {sample_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        frm_d = FRM_PARITY;
                    end
                end
                FRM_PARITY: begin
                    par_ok_d = odd_parity_ok(shift_q, sample_bit);
                    frm_d    = FRM_STOP;
                end
                FRM_STOP: begin
                    frm_d = FRM_IDLE;
                    if (sample_bit && par_ok_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: frm_d = FRM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_q        <= FRM_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_ok_q     <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frm_q        <= frm_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // shift_q stays frozen from the stop bit until the next start bit, so it
    // is still the received byte while byte_valid_q is high.
    always_comb begin
        dec_d         = dec_q;
        push          = 1'b0;
        push_evt.ext  = (dec_q == DEC_EXT) || (dec_q == DEC_EXT_BRK);
        push_evt.brk  = (dec_q == DEC_BRK) || (dec_q == DEC_EXT_BRK);
        push_evt.code = shift_q;
        if (frame_err_q || fifo_overflow) begin
            dec_d = DEC_BASE;
        end else if (byte_valid_q) begin
            if (shift_q == PS2_EXT) begin
                unique case (dec_q)
                    DEC_BASE: dec_d = DEC_EXT;
                    DEC_BRK:  dec_d = DEC_EXT_BRK;
                    default:  dec_d = dec_q;
                endcase
            end else if (shift_q == PS2_BRK) begin
                unique case (dec_q)
                    DEC_BASE: dec_d = DEC_BRK;
                    DEC_EXT:  dec_d = DEC_EXT_BRK;
                    default:  dec_d = dec_q;
                endcase
            end else begin
                push  = 1'b1;
                dec_d = DEC_BASE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= DEC_BASE;
        end else begin
            dec_q <= dec_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(push_evt),
        .pop_i      (evt_ready),
        .valid_o    (evt_valid),
        .head_o     (head_evt),
        .overflow_o (fifo_overflow)
    );

    assign evt_code  = head_evt.code;
    assign evt_ext   = head_evt.ext;
    assign evt_brk   = head_evt.brk;
    assign frame_err = frame_err_q;
    assign overflow  = fifo_overflow;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: serialises PS/2 frames bit by bit
// and checks decoded events, error/overflow pulses and FIFO behaviour.
module tb_ps2_scan_sequencer;

    localparam int HALF        = 8;
    localparam int TIMEOUT_CYC = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       frame_err;
    logic       overflow;

    int          errors = 0;
    int          checks = 0;
    int          ferr_cnt = 0;
    int          ovf_cnt = 0;
    int          lat = -1;
    logic [9:0]  obs_q[$];

    ps2_scan_sequencer #(
        .FIFO_DEPTH (4),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code (evt_code),
        .evt_ext  (evt_ext),
        .evt_brk  (evt_brk),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid && evt_ready) begin
                obs_q.push_back({evt_ext, evt_brk, evt_code});
            end
            if (frame_err) ferr_cnt++;
            if (overflow)  ovf_cnt++;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h req=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic expect_evt(input string tag, input int idx, input logic [9:0] exp);
        if (idx < obs_q.size()) begin
            check_eq(tag, {22'd0, obs_q[idx]}, {22'd0, exp});
        end else begin
            check_eq({tag, "_present"}, obs_q.size(), idx + 1);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    // Sends frame bits first..last. On the stop bit it measures cycles from the
    // falling edge to evt_valid, and can raise evt_ready for one cycle at k.
    task automatic send_range(input logic [10:0] f, input int first, input int last, input int rdy_k);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                lat = -1;
                for (int k = 1; k <= 8; k++) begin
                    @(posedge clk);
                    #1;
                    if (evt_valid && lat < 0) lat = k;
                    if (rdy_k != 0 && k == rdy_k)     evt_ready = 1'b1;
                    if (rdy_k != 0 && k == rdy_k + 1) evt_ready = 1'b0;
                end
                @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_range(mk_frame(d, 1'b0), 0, 10, 0);
    endtask

    initial begin
        int n0;
        int e0;
        int o0;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_valid", evt_valid, 0);
        check_eq("rst_code",  evt_code, 0);
        check_eq("rst_ext",   evt_ext, 0);
        check_eq("rst_brk",   evt_brk, 0);
        check_eq("rst_ferr",  frame_err, 0);
        check_eq("rst_ovf",   overflow, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Plain make code with latency measurement
        n0 = obs_q.size();
        send_byte(8'h1C);
        check_eq("t1_latency", lat, 4);
        check_eq("t1_count", obs_q.size(), n0 + 1);
        expect_evt("t1_evt", n0, {2'b00, 8'h1C});

        // Extended break sequence
        n0 = obs_q.size();
        send_byte(8'hE0);
        send_byte(8'hF0);
        check_eq("t2_prefix_none", obs_q.size(), n0);
        send_byte(8'h75);
        check_eq("t2_count", obs_q.size(), n0 + 1);
        expect_evt("t2_evt", n0, {2'b11, 8'h75});

        // Parity error then a clean break code
        n0 = obs_q.size();
        e0 = ferr_cnt;
        send_range(mk_frame(8'h1C, 1'b1), 0, 10, 0);
        check_eq("t3_ferr", ferr_cnt, e0 + 1);
        check_eq("t3_no_evt", obs_q.size(), n0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        expect_evt("t3_evt", n0, {2'b01, 8'h1C});

        // Overflow with consumer stalled
        evt_ready = 1'b0;
        n0 = obs_q.size();
        o0 = ovf_cnt;
        send_byte(8'h15);
        send_byte(8'h16);
        send_byte(8'h1D);
        send_byte(8'h24);
        check_eq("t4_no_ovf_yet", ovf_cnt, o0);
        send_byte(8'h2D);
        check_eq("t4_ovf", ovf_cnt, o0 + 1);
        check_eq("t4_valid", evt_valid, 1);
        check_eq("t4_head_hold", evt_code, 8'h15);
        @(negedge clk);
        evt_ready = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t4_drained", obs_q.size(), n0 + 4);
        expect_evt("t4_e0", n0,     {2'b00, 8'h15});
        expect_evt("t4_e1", n0 + 1, {2'b00, 8'h16});
        expect_evt("t4_e2", n0 + 2, {2'b00, 8'h1D});
        expect_evt("t4_e3", n0 + 3, {2'b00, 8'h24});
        check_eq("t4_empty", evt_valid, 0);

        // Full FIFO with a pop in the push cycle
        evt_ready = 1'b0;
        n0 = obs_q.size();
        o0 = ovf_cnt;
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h23);
        send_byte(8'h26);
        send_range(mk_frame(8'h25, 1'b0), 0, 10, 3);
        check_eq("t5_no_ovf", ovf_cnt, o0);
        check_eq("t5_one_pop", obs_q.size(), n0 + 1);
        @(negedge clk);
        evt_ready = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t5_count", obs_q.size(), n0 + 5);
        expect_evt("t5_e0", n0,     {2'b00, 8'h21});
        expect_evt("t5_e1", n0 + 1, {2'b00, 8'h22});
        expect_evt("t5_e2", n0 + 2, {2'b00, 8'h23});
        expect_evt("t5_e3", n0 + 3, {2'b00, 8'h26});
        expect_evt("t5_e4", n0 + 4, {2'b00, 8'h25});

        // Reset mid-frame; trailing ones are ignored
        n0 = obs_q.size();
        e0 = ferr_cnt;
        send_range(mk_frame(8'hF0, 1'b0), 0, 4, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t6_rst_valid", evt_valid, 0);
        rst = 1'b0;
        send_range(mk_frame(8'hF0, 1'b0), 5, 10, 0);
        check_eq("t6_no_evt", obs_q.size(), n0);
        check_eq("t6_no_ferr", ferr_cnt, e0);
        send_byte(8'h1C);
        expect_evt("t6_evt", n0, {2'b00, 8'h1C});

        // Stalled partial frame
        n0 = obs_q.size();
        e0 = ferr_cnt;
        send_range(mk_frame(8'h2A, 1'b0), 0, 4, 0);
`ifdef PS2_TIMEOUT_EN
        repeat (TIMEOUT_CYC + 50) @(negedge clk);
        check_eq("t7_timeout_ferr", ferr_cnt, e0 + 1);
        send_byte(8'h2A);
`else
        repeat (300) @(negedge clk);
        check_eq("t7_wait_no_ferr", ferr_cnt, e0);
        send_range(mk_frame(8'h2A, 1'b0), 5, 10, 0);
`endif
        check_eq("t7_count", obs_q.size(), n0 + 1);
        expect_evt("t7_evt", n0, {2'b00, 8'h2A});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
